// File: rtl/microsequencer_p.sv
// ---------------------------------------------------------------------------
// microsequencer_p
//
// Microprogram sequencer for the microcoded ARM datapath control path.
// It holds the micro-program counter (uPC) and selects the next
// micro-address each cycle from one of these sources: the sequential
// increment, a branch target, the opcode map, the return stack, or the
// loop-counter branch. The microcode ROM and the control-word pipeline
// register sit outside this block. Their fields come back in as
// NS_OP / COND_SEL / INV / BR_ADDR / LD_CNT / CNT_VAL.
//
// Ports
//   CLK       in   rising-edge clock
//   RESET_N   in   asynchronous active-low reset
//   HOLD      in   stall: all state frozen while high
//   NS_OP     in   next-state opcode (see ns_op_e)
//   COND_SEL  in   index into COND_VEC
//   INV       in   invert the selected condition
//   COND_VEC  in   condition inputs (MOC, COND, IR bits, MLS ...)
//   BR_ADDR   in   branch / call / loop target
//   MAP_ADDR  in   opcode-mapped address from the instruction encoder
//   LD_CNT    in   load the loop counter with CNT_VAL
//   CNT_VAL   in   loop counter load value
//   UADDR     out  current micro-address (uPC), drives the ROM
//   CNT_ZERO  out  loop counter is zero
//   SP_FULL   out  return stack holds DEPTH entries
//   ERR_OVF   out  sticky: push attempted while the stack was full
//   ERR_UNF   out  sticky: pop attempted while the stack was empty
// ---------------------------------------------------------------------------
module microsequencer_p #(
    parameter int              AW         = 8,
    parameter int              NCOND      = 8,
    parameter int              DEPTH      = 4,
    parameter int              CW         = 8,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     HOLD,
    input  logic [2:0]               NS_OP,
    input  logic [$clog2(NCOND)-1:0] COND_SEL,
    input  logic                     INV,
    input  logic [NCOND-1:0]         COND_VEC,
    input  logic [AW-1:0]            BR_ADDR,
    input  logic [AW-1:0]            MAP_ADDR,
    input  logic                     LD_CNT,
    input  logic [CW-1:0]            CNT_VAL,
    output logic [AW-1:0]            UADDR,
    output logic                     CNT_ZERO,
    output logic                     SP_FULL,
    output logic                     ERR_OVF,
    output logic                     ERR_UNF
);

    // The stack pointer counts 0..DEPTH, so it needs one more code than
    // there are stack entries.
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        NS_CONT = 3'd0,
        NS_JMP  = 3'd1,
        NS_CJMP = 3'd2,
        NS_MAP  = 3'd3,
        NS_CALL = 3'd4,
        NS_RET  = 3'd5,
        NS_LOOP = 3'd6,
        NS_WAIT = 3'd7
    } ns_op_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [AW-1:0]  upc_q;
    logic [SPW-1:0] sp_q;
    logic [CW-1:0]  cnt_q;
    logic           err_ovf_q;
    logic           err_unf_q;
    logic [AW-1:0]  stack_q [DEPTH];

    // ---------------------------------------------------------------------
    // Next-state signals
    // ---------------------------------------------------------------------
    ns_op_e         op;
    logic           cond;
    logic [AW-1:0]  inc;
    logic           sp_full;
    logic           sp_empty;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  top_idx;

    logic [AW-1:0]  upc_nxt;
    logic [SPW-1:0] sp_nxt;
    logic [CW-1:0]  cnt_nxt;
    logic           push_en;
    logic           ovf_set;
    logic           unf_set;

    assign op       = ns_op_e'(NS_OP);
    assign cond     = COND_VEC[COND_SEL] ^ INV;
    assign inc      = upc_q + 1'b1;               // wraps all-ones to zero
    assign sp_full  = (sp_q == SPW'(DEPTH));
    assign sp_empty = (sp_q == '0);
    assign push_idx = IW'(sp_q);                  // only used when not full
    assign top_idx  = IW'(sp_q - 1'b1);           // only used when not empty

    // NOTE: every output of this block gets a default before the case
    // statement. A path that skipped an assignment would infer a latch.
    always_comb begin
        upc_nxt = inc;
        sp_nxt  = sp_q;
        cnt_nxt = cnt_q;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        unique case (op)
            NS_CONT: upc_nxt = inc;
            NS_JMP:  upc_nxt = BR_ADDR;
            NS_CJMP: upc_nxt = cond ? BR_ADDR : inc;
            NS_MAP:  upc_nxt = MAP_ADDR;
            NS_CALL: begin
                if (cond) begin
                    upc_nxt = BR_ADDR;
                    // The call still jumps on overflow. Only the return
                    // address is lost.
                    if (sp_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_nxt  = sp_q + 1'b1;
                    end
                end
            end
            NS_RET: begin
                if (sp_empty) begin
                    upc_nxt = RESET_ADDR;
                    unf_set = 1'b1;
                end else begin
                    upc_nxt = stack_q[top_idx];
                    sp_nxt  = sp_q - 1'b1;
                end
            end
            NS_LOOP: begin
                if (cnt_q != '0) begin
                    upc_nxt = BR_ADDR;
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            NS_WAIT: upc_nxt = cond ? inc : upc_q;
            default: upc_nxt = inc;
        endcase

        // A load wins over a same-cycle decrement. The LOOP branch above
        // was already decided from the pre-load count.
        if (LD_CNT) begin
            cnt_nxt = CNT_VAL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            upc_q     <= RESET_ADDR;
            sp_q      <= '0;
            cnt_q     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else if (!HOLD) begin
            upc_q     <= upc_nxt;
            sp_q      <= sp_nxt;
            cnt_q     <= cnt_nxt;
            err_ovf_q <= err_ovf_q | ovf_set;
            err_unf_q <= err_unf_q | unf_set;
        end
    end

    // NOTE: the stack entries have no reset. An entry is only read after
    // it has been pushed, and the pointer itself is reset, so stale
    // contents can never be observed.
    always_ff @(posedge CLK) begin
        if (push_en && !HOLD) begin
            stack_q[push_idx] <= inc;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs are decoded from registered state only
    // ---------------------------------------------------------------------
    assign UADDR    = upc_q;
    assign CNT_ZERO = (cnt_q == '0);
    assign SP_FULL  = sp_full;
    assign ERR_OVF  = err_ovf_q;
    assign ERR_UNF  = err_unf_q;

endmodule

// File: tb/tb_microsequencer_p.sv
// ---------------------------------------------------------------------------
// tb_microsequencer_p
//
// Self-checking bench for microsequencer_p. The bench runs the directed
// scenarios first and then a randomized run. A behavioural model tracks
// uPC, the return stack (a queue), the loop count and the sticky error
// flags, and every cycle is compared against it.
// ---------------------------------------------------------------------------
module tb_microsequencer_p;

    localparam int AW    = 8;
    localparam int NCOND = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic                     CLK = 1'b0;
    logic                     RESET_N;
    logic                     HOLD;
    logic [2:0]               NS_OP;
    logic [$clog2(NCOND)-1:0] COND_SEL;
    logic                     INV;
    logic [NCOND-1:0]         COND_VEC;
    logic [AW-1:0]            BR_ADDR;
    logic [AW-1:0]            MAP_ADDR;
    logic                     LD_CNT;
    logic [CW-1:0]            CNT_VAL;
    logic [AW-1:0]            UADDR;
    logic                     CNT_ZERO;
    logic                     SP_FULL;
    logic                     ERR_OVF;
    logic                     ERR_UNF;

    microsequencer_p #(
        .AW(AW), .NCOND(NCOND), .DEPTH(DEPTH), .CW(CW), .RESET_ADDR(8'h00)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .HOLD(HOLD), .NS_OP(NS_OP),
        .COND_SEL(COND_SEL), .INV(INV), .COND_VEC(COND_VEC),
        .BR_ADDR(BR_ADDR), .MAP_ADDR(MAP_ADDR), .LD_CNT(LD_CNT),
        .CNT_VAL(CNT_VAL), .UADDR(UADDR), .CNT_ZERO(CNT_ZERO),
        .SP_FULL(SP_FULL), .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_upc;
    int m_cnt;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    task automatic model_reset();
        m_upc = 0;
        m_cnt = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Applies the opcode rules to the inputs that the coming edge samples.
    task automatic model_step();
        int c;
        int inc;
        int new_cnt;
        if (HOLD) return;
        c       = int'(COND_VEC[COND_SEL]) ^ int'(INV);
        inc     = (m_upc + 1) % 256;
        new_cnt = m_cnt;
        case (NS_OP)
            3'd0: m_upc = inc;
            3'd1: m_upc = BR_ADDR;
            3'd2: m_upc = c ? int'(BR_ADDR) : inc;
            3'd3: m_upc = MAP_ADDR;
            3'd4: if (c) begin
                      if (m_stack.size() == DEPTH) m_ovf = 1;
                      else m_stack.push_back(inc);
                      m_upc = BR_ADDR;
                  end else m_upc = inc;
            3'd5: if (m_stack.size() == 0) begin
                      m_upc = 0;
                      m_unf = 1;
                  end else m_upc = m_stack.pop_back();
            3'd6: if (m_cnt != 0) begin
                      new_cnt = m_cnt - 1;
                      m_upc   = BR_ADDR;
                  end else m_upc = inc;
            default: m_upc = c ? inc : m_upc;
        endcase
        if (LD_CNT) new_cnt = CNT_VAL;
        m_cnt = new_cnt;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".uaddr"}, 32'(UADDR), 32'(m_upc));
        check({tag, ".cnt_zero"}, 32'(CNT_ZERO), 32'(m_cnt == 0));
        check({tag, ".sp_full"}, 32'(SP_FULL), 32'(m_stack.size() == DEPTH));
        check({tag, ".err_ovf"}, 32'(ERR_OVF), 32'(m_ovf));
        check({tag, ".err_unf"}, 32'(ERR_UNF), 32'(m_unf));
    endtask

    // One clock: the model consumes the current inputs, then the outputs
    // are sampled 1 ns after the edge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [2:0] op, input logic [AW-1:0] br);
        NS_OP   = op;
        BR_ADDR = br;
    endtask

    initial begin
        RESET_N  = 1'b0;
        HOLD     = 1'b0;
        NS_OP    = 3'd0;
        COND_SEL = '0;
        INV      = 1'b0;
        COND_VEC = '0;
        BR_ADDR  = '0;
        MAP_ADDR = '0;
        LD_CNT   = 1'b0;
        CNT_VAL  = '0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.uaddr_const", 32'(UADDR), 32'h0);
        check("reset.cnt_zero_const", 32'(CNT_ZERO), 32'h1);
        RESET_N = 1'b1;

        // Sequential run and wrap-around.
        drive(3'd0, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            cycle("cont");
            check("cont.addr", 32'(UADDR), 32'(i));
        end
        drive(3'd1, 8'hFF); cycle("jmp_ff");
        drive(3'd0, 8'h00); cycle("wrap");
        check("wrap.addr", 32'(UADDR), 32'h00);

        // WAIT on MOC (bit 0), then with the condition inverted.
        for (int pol = 0; pol < 2; pol++) begin
            INV = pol[0];
            COND_VEC[0] = pol[0];
            drive(3'd7, 8'h00);
            for (int i = 0; i < 3; i++) cycle("wait_hold");
            check("wait.held", 32'(UADDR), 32'h00);
            COND_VEC[0] = ~pol[0];
            cycle("wait_go");
            check("wait.advanced", 32'(UADDR), 32'h01);
            drive(3'd1, 8'h00); cycle("back_to_0");
        end
        INV = 1'b0;
        COND_VEC[0] = 1'b1;

        // Single call / return.
        drive(3'd1, 8'h10); cycle("jmp_10");
        drive(3'd4, 8'h40); cycle("call_40");
        check("call.target", 32'(UADDR), 32'h40);
        drive(3'd5, 8'h00); cycle("ret");
        check("ret.addr", 32'(UADDR), 32'h11);

        // Nest four calls from 0x11 to fill the stack, then overflow it.
        drive(3'd4, 8'h20); cycle("nest1");
        drive(3'd4, 8'h30); cycle("nest2");
        drive(3'd4, 8'h40); cycle("nest3");
        drive(3'd4, 8'h50); cycle("nest4");
        check("nest.sp_full", 32'(SP_FULL), 32'h1);
        drive(3'd4, 8'h60); cycle("call_ovf");
        check("ovf.target", 32'(UADDR), 32'h60);
        check("ovf.flag", 32'(ERR_OVF), 32'h1);
        drive(3'd5, 8'h00);
        cycle("unwind1"); check("unwind1.addr", 32'(UADDR), 32'h41);
        cycle("unwind2"); check("unwind2.addr", 32'(UADDR), 32'h31);
        cycle("unwind3"); check("unwind3.addr", 32'(UADDR), 32'h21);
        cycle("unwind4"); check("unwind4.addr", 32'(UADDR), 32'h12);
        cycle("ret_unf");
        check("unf.addr", 32'(UADDR), 32'h00);
        check("unf.flag", 32'(ERR_UNF), 32'h1);

        // Three-pass hardware loop over 0x20..0x22.
        LD_CNT = 1'b1; CNT_VAL = 8'd3;
        drive(3'd1, 8'h20); cycle("ld_cnt");
        LD_CNT = 1'b0;
        for (int pass = 0; pass < 3; pass++) begin
            drive(3'd0, 8'h00); cycle("body"); cycle("body");
            drive(3'd6, 8'h20); cycle("loop_taken");
            check("loop.branch", 32'(UADDR), 32'h20);
        end
        check("loop.cnt_zero", 32'(CNT_ZERO), 32'h1);
        drive(3'd0, 8'h00); cycle("body"); cycle("body");
        drive(3'd6, 8'h20); cycle("loop_exit");
        check("loop.fallthrough", 32'(UADDR), 32'h23);

        // MAP held off by HOLD.
        MAP_ADDR = 8'h5A;
        HOLD = 1'b1;
        drive(3'd3, 8'h00);
        cycle("hold1"); cycle("hold2");
        check("hold.frozen", 32'(UADDR), 32'h23);
        HOLD = 1'b0;
        cycle("map");
        check("map.addr", 32'(UADDR), 32'h5A);

        // Asynchronous reset mid-loop with SP=2 and the overflow flag set.
        drive(3'd4, 8'h70); cycle("pre_rst_call1");
        drive(3'd4, 8'h80); cycle("pre_rst_call2");
        LD_CNT = 1'b1; CNT_VAL = 8'd5;
        drive(3'd1, 8'h90); cycle("pre_rst_ld");
        LD_CNT = 1'b0;
        drive(3'd6, 8'h90); cycle("pre_rst_loop");
        check("pre_rst.ovf", 32'(ERR_OVF), 32'h1);
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst.uaddr", 32'(UADDR), 32'h00);
        check("async_rst.ovf", 32'(ERR_OVF), 32'h0);
        RESET_N = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            NS_OP    = 3'($urandom_range(0, 7));
            BR_ADDR  = 8'($urandom);
            MAP_ADDR = 8'($urandom);
            COND_VEC = 8'($urandom);
            COND_SEL = 3'($urandom_range(0, 7));
            INV      = 1'($urandom);
            HOLD     = ($urandom_range(0, 7) == 0);
            LD_CNT   = ($urandom_range(0, 5) == 0);
            CNT_VAL  = 8'($urandom_range(0, 4));
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/microsequencer_p.md
Name: microsequencer_p

Overview:
- Parametrised microprogram sequencer for the microcoded ARM datapath control path.
- Holds the micro-program counter (uPC) and computes the next micro-address each cycle. Sources are sequential, branch, opcode-map, return stack or loop counter.
- Adds to the fixed 8-bit next-state scheme: generic widths, a selectable condition vector, a micro-subroutine call/return stack and a hardware loop counter.
- The microcode ROM and the control-word pipeline register are external; their fields feed back into this block.

Parameters:
AW, 8, micro-address width
NCOND, 8, number of condition inputs (power of 2, min 2)
DEPTH, 4, return-stack entries (min 1)
CW, 8, loop-counter width
RESET_ADDR, 0, uPC value after reset and on stack underflow

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
HOLD  in  1  stall: all state frozen while high
NS_OP  in  3  next-state opcode from control word
COND_SEL  in  clog2(NCOND)  condition select
INV  in  1  invert selected condition
COND_VEC  in  NCOND  condition inputs (MOC, COND, IR bits, MLS...)
BR_ADDR  in  AW  branch/target address from control word
MAP_ADDR  in  AW  opcode-mapped address from instruction encoder
LD_CNT  in  1  load loop counter
CNT_VAL  in  CW  loop counter load value
UADDR  out  AW  current micro-address (= uPC), drives ROM
CNT_ZERO  out  1  loop counter == 0
SP_FULL  out  1  stack holds DEPTH entries
ERR_OVF  out  1  sticky: push attempted when full
ERR_UNF  out  1  sticky: pop attempted when empty

Behaviour:
- Reset (async, RESET_N low):
  - uPC = RESET_ADDR; stack pointer = 0; counter = 0.
  - ERR_OVF = 0, ERR_UNF = 0; CNT_ZERO = 1; SP_FULL = 0.
  - Reset mid-operation discards all state immediately.
- Condition: c = COND_VEC[COND_SEL] XOR INV. Purely combinational from current inputs.
- inc = uPC + 1 modulo 2^AW; all-ones wraps to 0.
- On each rising CLK with HOLD = 0, uPC is updated by NS_OP:
  - 0 CONT: inc
  - 1 JMP: BR_ADDR
  - 2 CJMP: c ? BR_ADDR : inc
  - 3 MAP: MAP_ADDR
  - 4 CALL: if c, push inc and go to BR_ADDR; else inc
  - 5 RET: pop top of stack into uPC
  - 6 LOOP: if counter != 0, counter -= 1 and go to BR_ADDR; else inc
  - 7 WAIT: c ? inc : uPC (hold in place, e.g. waiting on MOC)
- Latency: UADDR reflects the new address one cycle after the control word is presented; there are no bypass paths.
- Stack is LIFO of AW-bit entries.
  - Push when SP = DEPTH: entry dropped, jump still taken, ERR_OVF set.
  - RET when SP = 0: uPC = RESET_ADDR, SP stays 0, ERR_UNF set.
  - Error flags clear only on reset.
- Loop counter:
  - LD_CNT = 1 loads CNT_VAL at the edge and takes priority over a LOOP decrement in the same cycle. In that case uPC still branches if the pre-load counter was != 0.
  - Counter never decrements below 0.
- HOLD = 1: uPC, SP, stack contents, counter and flags are unchanged, including LD_CNT being ignored. HOLD has no effect on reset.
- SP_FULL and CNT_ZERO are decoded directly from registered state (registered-derived, glitch-free).
- Undefined or X inputs need not be handled. Every NS_OP encoding is defined.

Test Plan:
- Reset then CONT ×3 from RESET_ADDR = 0 -> UADDR 0, 1, 2, 3. Preload uPC = 8'hFF via JMP, then CONT -> UADDR = 8'h00.
- WAIT with COND_SEL = 0 (MOC), INV = 0: MOC low for 3 cycles -> UADDR holds. MOC high -> UADDR advances by 1 next cycle. Repeat with INV = 1 -> opposite polarity.
- CALL to 8'h40 from 8'h10 with c = 1, then RET at 8'h40 -> UADDR 8'h40 then 8'h11. Nested calls to DEPTH = 4 -> SP_FULL = 1. 5th CALL -> jump taken, ERR_OVF = 1. Four RETs unwind in correct order. 5th RET -> UADDR = RESET_ADDR, ERR_UNF = 1.
- LD_CNT with CNT_VAL = 3, then LOOP to 8'h20 at 8'h22 -> branch taken 3 times, counter 2, 1, 0. CNT_ZERO = 1, 4th LOOP falls to 8'h23.
- MAP with MAP_ADDR = 8'h5A while HOLD = 1 for 2 cycles -> UADDR unchanged. HOLD drops -> UADDR = 8'h5A.
- Assert RESET_N low mid-loop with SP = 2 and ERR_OVF = 1 -> all outputs return to reset values asynchronously, without waiting for a CLK edge.
